vote_round_ctrl: RTL and testbench

- Sequences voting rounds for the 8-voter fail/safe tally.
- On `start`, collects one vote per enabled voter via per-voter valid strobes, with a timeout. Voters that miss the timeout count as fail.
- Produces the round verdict, then applies a persistence filter: `trip` asserts only after PERSIST_MAX-bounded consecutive failing rounds, and latches until acknowledged.
- Sits between the raw voter pins and the top-level output mux; it is the block that decides when a tally is taken and what it means over time.

---
 rtl/vote_pkg.sv | 30 +++
 rtl/vote_tally.sv | 18 +
 rtl/vote_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_vote_round_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the voting round controller and the combinational tally.
package vote_pkg;

    localparam int N_VOTERS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2
    } state_e;

    function automatic logic [3:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Lanes 0..n-1 set; n is already clamped to N_VOTERS by the caller.
    function automatic logic [N_VOTERS-1:0] lane_mask(input logic [3:0] n);
        logic [N_VOTERS-1:0] m;
        for (int i = 0; i < N_VOTERS; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/vote_tally.sv
// Combinational fail tally: explicit fail votes plus missing voters, compared to the tolerance.
module vote_tally
    import vote_pkg::*;
(
    input  logic [N_VOTERS-1:0] vote_i,
    input  logic [N_VOTERS-1:0] got_i,
    input  logic [N_VOTERS-1:0] enabled_i,
    input  logic [2:0]          fails_okay_i,
    output logic [N_VOTERS-1:0] missing_o,
    output logic [3:0]          fail_count_o,
    output logic                fail_o
);

    assign missing_o    = enabled_i & ~got_i;
    assign fail_count_o = popcount(vote_i & got_i & enabled_i) + popcount(missing_o);
    assign fail_o       = fail_count_o > {1'b0, fails_okay_i};

endmodule

// File: rtl/vote_round_ctrl.sv
// Voting round sequencer: collects per-voter strobes with a timeout, tallies the round,
// and runs a consecutive-failure persistence filter driving a latched trip alarm.
module vote_round_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int PERSIST_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [N_VOTERS-1:0]  voter_valid,
    input  logic [N_VOTERS-1:0]  voter_vote,
    input  logic [3:0]           num_voters,
    input  logic [2:0]           num_fails_okay,
    input  logic [PERSIST_W-1:0] persist_rounds,
    input  logic                 ack,
    output logic                 busy,
    output logic                 round_done,
    output logic                 round_fail,
    output logic [3:0]           fail_count,
    output logic [N_VOTERS-1:0]  missing_mask,
    output logic [PERSIST_W-1:0] consec_fails,
    output logic                 trip
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PERSIST_W-1:0] CONSEC_MAX = {PERSIST_W{1'b1}};

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [3:0]           cfg_n_q, cfg_n_d;
    logic [2:0]           cfg_ok_q, cfg_ok_d;
    logic [PERSIST_W-1:0] cfg_p_q, cfg_p_d;
    logic [N_VOTERS-1:0]  got_q, got_d;
    logic [N_VOTERS-1:0]  vote_q, vote_d;
    logic                 round_done_q, round_done_d;
    logic                 round_fail_q, round_fail_d;
    logic [3:0]           fail_count_q, fail_count_d;
    logic [N_VOTERS-1:0]  missing_q, missing_d;
    logic [PERSIST_W-1:0] consec_q, consec_d;
    logic                 trip_q, trip_d;

    logic [N_VOTERS-1:0]  enabled;
    logic [N_VOTERS-1:0]  take;
    logic                 got_all;
    logic [N_VOTERS-1:0]  tally_missing;
    logic [3:0]           tally_count;
    logic                 tally_fail;
    logic [PERSIST_W-1:0] consec_next;

    assign enabled = lane_mask(cfg_n_q);
    // Only lanes that have not voted yet accept a strobe: first vote wins.
    assign take    = voter_valid & enabled & ~got_q;
    assign got_all = ((got_q | take) & enabled) == enabled;

    vote_tally u_tally (
        .vote_i       (vote_q),
        .got_i        (got_q),
        .enabled_i    (enabled),
        .fails_okay_i (cfg_ok_q),
        .missing_o    (tally_missing),
        .fail_count_o (tally_count),
        .fail_o       (tally_fail)
    );

    assign consec_next = !tally_fail ? '0 :
                         (consec_q == CONSEC_MAX) ? consec_q : consec_q + PERSIST_W'(1);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cfg_n_d      = cfg_n_q;
        cfg_ok_d     = cfg_ok_q;
        cfg_p_d      = cfg_p_q;
        got_d        = got_q;
        vote_d       = vote_q;
        round_done_d = round_done_q;
        round_fail_d = round_fail_q;
        fail_count_d = fail_count_q;
        missing_d    = missing_q;
        consec_d     = consec_q;
        trip_d       = trip_q;
        if (ena) begin
            round_done_d = 1'b0;
            if (ack) begin
                trip_d   = 1'b0;
                consec_d = '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = COLLECT;
                        cfg_n_d  = (num_voters > 4'd8) ? 4'd8 : num_voters;
                        cfg_ok_d = num_fails_okay;
                        cfg_p_d  = (persist_rounds == '0) ? PERSIST_W'(1) : persist_rounds;
                        got_d    = '0;
                        vote_d   = '0;
                        timer_d  = '0;
                    end
                end
                COLLECT: begin
                    got_d  = got_q | take;
                    vote_d = (vote_q & ~take) | (voter_vote & take);
                    if (got_all || timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = DECIDE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                DECIDE: begin
                    state_d      = IDLE;
                    round_done_d = 1'b1;
                    round_fail_d = tally_fail;
                    fail_count_d = tally_count;
                    missing_d    = tally_missing;
                    // The round's count overrides a coincident ack; a new trip beats the ack.
                    consec_d     = consec_next;
                    if (consec_next >= cfg_p_q) begin
                        trip_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cfg_n_q      <= '0;
            cfg_ok_q     <= '0;
            cfg_p_q      <= '0;
            got_q        <= '0;
            vote_q       <= '0;
            round_done_q <= 1'b0;
            round_fail_q <= 1'b0;
            fail_count_q <= '0;
            missing_q    <= '0;
            consec_q     <= '0;
            trip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cfg_n_q      <= cfg_n_d;
            cfg_ok_q     <= cfg_ok_d;
            cfg_p_q      <= cfg_p_d;
            got_q        <= got_d;
            vote_q       <= vote_d;
            round_done_q <= round_done_d;
            round_fail_q <= round_fail_d;
            fail_count_q <= fail_count_d;
            missing_q    <= missing_d;
            consec_q     <= consec_d;
            trip_q       <= trip_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign round_done   = round_done_q & ena;
    assign round_fail   = round_fail_q;
    assign fail_count   = fail_count_q;
    assign missing_mask = missing_q;
    assign consec_fails = consec_q;
    assign trip         = trip_q;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Bench for vote_round_ctrl: directed scenarios plus randomized rounds against a lane-level model.
module tb_vote_round_ctrl;

    localparam int TIMEOUT = 16;
    localparam int PW      = 3;
    localparam int CMAX    = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [7:0]    voter_valid = '0;
    logic [7:0]    voter_vote = '0;
    logic [3:0]    num_voters = '0;
    logic [2:0]    num_fails_okay = '0;
    logic [PW-1:0] persist_rounds = '0;
    logic          busy, round_done, round_fail, trip;
    logic [3:0]    fail_count;
    logic [7:0]    missing_mask;
    logic [PW-1:0] consec_fails;

    int n_pass = 0;
    int n_total = 0;

    // Model's view of the state carried between rounds.
    int m_consec = 0;
    bit m_trip = 0;

    // Per-collect-cycle strobe pattern for the next round.
    logic [7:0] sv_valid[TIMEOUT];
    logic [7:0] sv_vote[TIMEOUT];

    vote_round_ctrl #(.TIMEOUT(TIMEOUT), .PERSIST_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .start          (start),
        .voter_valid    (voter_valid),
        .voter_vote     (voter_vote),
        .num_voters     (num_voters),
        .num_fails_okay (num_fails_okay),
        .persist_rounds (persist_rounds),
        .ack            (ack),
        .busy           (busy),
        .round_done     (round_done),
        .round_fail     (round_fail),
        .fail_count     (fail_count),
        .missing_mask   (missing_mask),
        .consec_fails   (consec_fails),
        .trip           (trip)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < TIMEOUT; c++) begin
            sv_valid[c] = '0;
            sv_vote[c]  = '0;
        end
    endtask

    task automatic fill_random();
        int r;
        for (int c = 0; c < TIMEOUT; c++) begin
            r = $urandom_range(0, 3);
            sv_valid[c] = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
            sv_vote[c]  = 8'($urandom);
        end
    endtask

    // Runs one full round with the current strobe pattern and checks timing and results.
    task automatic do_round(input string name, input int n, input int ok, input int p,
                            input bit ack_dec, input int freeze_at, input bit start_busy);
        int en, pp, used, fails, exp_edges, edges, c;
        bit all_in, rf;
        logic [7:0] got, vt, miss;
        en = (n > 8) ? 8 : n;
        pp = (p == 0) ? 1 : p;
        got = '0; vt = '0; miss = '0; used = 0;
        for (int cy = 0; cy < TIMEOUT; cy++) begin
            used = cy + 1;
            for (int i = 0; i < en; i++) begin
                if (sv_valid[cy][i] && !got[i]) begin
                    got[i] = 1'b1;
                    vt[i]  = sv_vote[cy][i];
                end
            end
            all_in = 1;
            for (int i = 0; i < en; i++) if (!got[i]) all_in = 0;
            if (all_in) break;
        end
        fails = 0;
        for (int i = 0; i < en; i++) begin
            if (!got[i]) begin
                miss[i] = 1'b1;
                fails++;
            end else if (vt[i]) begin
                fails++;
            end
        end
        rf = (fails > ok);
        m_consec = rf ? ((m_consec < CMAX) ? m_consec + 1 : CMAX) : 0;
        if (m_consec >= pp) m_trip = 1;
        else if (ack_dec) m_trip = 0;
        exp_edges = used + 1 + ((freeze_at >= 0 && freeze_at <= used) ? 5 : 0);

        num_voters = 4'(n);
        num_fails_okay = 3'(ok);
        persist_rounds = PW'(p);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_voters = 4'($urandom);
        num_fails_okay = 3'($urandom);
        persist_rounds = PW'($urandom);
        edges = -1;
        for (int k = 0; k < TIMEOUT + 12; k++) begin
            c = k;
            ena = 1'b1;
            voter_valid = '0;
            voter_vote = 8'($urandom);
            if (freeze_at >= 0 && k >= freeze_at && k < freeze_at + 5) begin
                ena = 1'b0;
                voter_valid = 8'($urandom);
            end else begin
                if (freeze_at >= 0 && k >= freeze_at + 5) c = k - 5;
                if (c < TIMEOUT) begin
                    voter_valid = sv_valid[c];
                    voter_vote  = sv_vote[c];
                end
            end
            start = start_busy && (k == 0);
            ack = ack_dec && (k == exp_edges - 1);
            tick();
            if (round_done === 1'b1) begin
                edges = k + 1;
                break;
            end
        end
        start = 1'b0; ack = 1'b0; ena = 1'b1; voter_valid = '0;

        n_total++;
        if (edges !== exp_edges) $display("FAIL %s done_latency got %0d want %0d", name, edges, exp_edges);
        else n_pass++;
        n_total++;
        if (fail_count !== 4'(fails)) $display("FAIL %s fail_count got %0d want %0d", name, fail_count, fails);
        else n_pass++;
        n_total++;
        if (round_fail !== rf) $display("FAIL %s round_fail got %0b want %0b", name, round_fail, rf);
        else n_pass++;
        n_total++;
        if (missing_mask !== miss) $display("FAIL %s missing_mask got %02h want %02h", name, missing_mask, miss);
        else n_pass++;
        n_total++;
        if (consec_fails !== PW'(m_consec)) $display("FAIL %s consec_fails got %0d want %0d", name, consec_fails, m_consec);
        else n_pass++;
        n_total++;
        if (trip !== m_trip) $display("FAIL %s trip got %0b want %0b", name, trip, m_trip);
        else n_pass++;
        tick();
        n_total++;
        if (round_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_round done/busy got %0b/%0b want 0/0", name, round_done, busy);
        else n_pass++;
    endtask

    task automatic do_ack(input string name);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        m_consec = 0;
        m_trip = 0;
        n_total++;
        if (trip !== 1'b0 || consec_fails !== '0)
            $display("FAIL %s ack_clear trip/consec got %0b/%0d want 0/0", name, trip, consec_fails);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick(); tick(); tick();
        n_total++;
        if ({busy, round_done, round_fail, fail_count, missing_mask, consec_fails, trip} !== '0)
            $display("FAIL reset outputs got %0h want 0",
                     {busy, round_done, round_fail, fail_count, missing_mask, consec_fails, trip});
        else n_pass++;
        rst_n = 1'b1;
        ena = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_collect();
        bit saw_done;
        num_voters = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        voter_valid = 8'h03;
        voter_vote = 8'h01;
        tick();
        voter_valid = '0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_mid busy_before got %0b want 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, round_done, round_fail, fail_count, missing_mask, consec_fails, trip} !== '0)
            $display("FAIL reset_mid outputs got %0h want 0",
                     {busy, round_done, round_fail, fail_count, missing_mask, consec_fails, trip});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        m_consec = 0;
        m_trip = 0;
        saw_done = 0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            tick();
            if (round_done === 1'b1 || busy !== 1'b0) saw_done = 1;
        end
        n_total++;
        if (saw_done) $display("FAIL reset_mid aborted_round got activity want none");
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_stim();
        sv_valid[0] = 8'h1F;
        sv_vote[0]  = 8'h03;
        do_round("basic", 5, 1, 7, 0, -1, 0);
    endtask

    task automatic test_timeout();
        clear_stim();
        sv_valid[0] = 8'h03;
        sv_vote[0]  = 8'h00;
        do_round("timeout", 4, 3, 7, 0, -1, 0);
    endtask

    task automatic test_persistence();
        do_ack("persist_pre");
        clear_stim();
        sv_valid[0] = 8'hFF;
        sv_vote[0]  = 8'hFF;
        do_round("persist_r1", 8, 0, 3, 0, -1, 0);
        do_round("persist_r2", 8, 0, 3, 0, -1, 0);
        do_round("persist_r3", 8, 0, 3, 0, -1, 0);
        sv_vote[0]  = 8'h00;
        do_round("persist_pass", 8, 0, 3, 0, -1, 0);
        do_ack("persist_ack");
    endtask

    task automatic test_saturation();
        clear_stim();
        sv_valid[0] = 8'h07;
        sv_vote[0]  = 8'h07;
        for (int r = 0; r < CMAX + 2; r++) do_round("saturate", 3, 0, 0, 0, -1, 0);
        do_ack("saturate_ack");
    endtask

    task automatic test_edges();
        clear_stim();
        sv_valid[0] = 8'hFF;
        sv_vote[0]  = 8'hFF;
        do_round("zero_voters", 0, 0, 7, 0, -1, 0);
        do_round("twelve_voters", 12, 7, 7, 0, -1, 0);
        clear_stim();
        sv_valid[0] = 8'h04; sv_vote[0] = 8'h04;
        sv_valid[1] = 8'h1F; sv_vote[1] = 8'h00;
        do_round("dup_lane2", 5, 0, 7, 0, -1, 0);
        clear_stim();
        sv_valid[2] = 8'h07; sv_vote[2] = 8'h01;
        do_round("start_busy", 3, 0, 7, 0, -1, 1);
    endtask

    task automatic test_ack_coincide();
        do_ack("coincide_pre");
        clear_stim();
        sv_valid[0] = 8'h03;
        sv_vote[0]  = 8'h03;
        do_round("ack_coincide", 2, 0, 1, 1, -1, 0);
        do_ack("coincide_post");
    endtask

    task automatic test_ena_freeze();
        clear_stim();
        sv_valid[0] = 8'h01; sv_vote[0] = 8'h01;
        sv_valid[3] = 8'h06; sv_vote[3] = 8'h00;
        do_round("ena_freeze", 6, 2, 7, 0, 2, 0);
    endtask

    task automatic test_random();
        int fz;
        for (int r = 0; r < 25; r++) begin
            fill_random();
            fz = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
            do_round("random", $urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, CMAX),
                     ($urandom_range(0, 4) == 0), fz, $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_collect();
        test_basic();
        test_timeout();
        test_persistence();
        test_saturation();
        test_edges();
        test_ack_coincide();
        test_ena_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
